// File: rtl/cheshire_eoc_monitor.sv
// rtl/cheshire_eoc_monitor.sv - multi-channel end-of-computation monitor with timeout, fail-fast and drain gate
//
// Collects exit-code writes from NumChan sources and aggregates them into one
// SoC-level verdict. Sources can be harts, JTAG, the serial link or UART debug.
// The FSM runs IDLE -> RUN -> DRAIN -> DONE. The verdict is held in DONE until
// the next arm pulse.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   arm_i              start / re-arm pulse (honoured in IDLE and DONE only)
//   timeout_cycles_i   RUN-cycle limit, 0 disables the timeout
//   stop_on_fail_i     fail-fast enable, latched on arm
//   ch_wvalid_i        per-channel write strobe
//   ch_wdata_i         per-channel write data, bit 0 = done, [DataWidth-1:1] = code
//   drain_busy_i       downstream still flushing, holds the verdict in DRAIN
//   busy_o             RUN or DRAIN
//   eoc_o              verdict valid (DONE)
//   exit_code_o        aggregated exit code
//   timeout_o          verdict caused by timeout
//   fail_chan_o        index of the reporting channel
//   ch_done_o          per-channel done flags
module cheshire_eoc_monitor #(
  parameter int NumChan      = 2,
  parameter int DataWidth    = 32,
  parameter int TimeoutWidth = 32,
  localparam int ChanIdxW    = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         arm_i,
  input  logic [TimeoutWidth-1:0]      timeout_cycles_i,
  input  logic                         stop_on_fail_i,
  input  logic [NumChan-1:0]           ch_wvalid_i,
  input  logic [NumChan*DataWidth-1:0] ch_wdata_i,
  input  logic                         drain_busy_i,
  output logic                         busy_o,
  output logic                         eoc_o,
  output logic [DataWidth-2:0]         exit_code_o,
  output logic                         timeout_o,
  output logic [ChanIdxW-1:0]          fail_chan_o,
  output logic [NumChan-1:0]           ch_done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_q;
  logic                      stop_on_fail_q;
  logic [TimeoutWidth-1:0]   cnt_q;
  logic [NumChan-1:0]        ch_done_q;
  logic [DataWidth-2:0]      code_q   [NumChan];

  // Post-update view of the channel state. Exit conditions are evaluated on
  // this view, so a completing write exits RUN in the same cycle it arrives.
  logic [NumChan-1:0]        done_nxt;
  logic [DataWidth-2:0]      code_nxt [NumChan];
  logic                      any_fail;
  logic [ChanIdxW-1:0]       fail_idx;
  logic [DataWidth-2:0]      fail_code;
  logic                      all_done;
  logic                      undone_found;
  logic [ChanIdxW-1:0]       undone_idx;
  logic                      timeout_hit;

  always_comb begin
    done_nxt     = ch_done_q;
    any_fail     = 1'b0;
    fail_idx     = '0;
    fail_code    = '0;
    all_done     = 1'b1;
    undone_found = 1'b0;
    undone_idx   = '0;
    for (int i = 0; i < NumChan; i++) begin
      code_nxt[i] = code_q[i];
      // First code wins: only a not-yet-done channel accepts a done write.
      if (state_q == RUN && ch_wvalid_i[i] && ch_wdata_i[i*DataWidth] && !ch_done_q[i]) begin
        done_nxt[i] = 1'b1;
        code_nxt[i] = ch_wdata_i[i*DataWidth+1 +: DataWidth-1];
      end
      // Ascending scan with a found flag gives lowest-index priority.
      if (!any_fail && done_nxt[i] && code_nxt[i] != '0) begin
        any_fail  = 1'b1;
        fail_idx  = ChanIdxW'(i);
        fail_code = code_nxt[i];
      end
      if (!done_nxt[i]) begin
        all_done = 1'b0;
        if (!undone_found) begin
          undone_found = 1'b1;
          undone_idx   = ChanIdxW'(i);
        end
      end
    end
  end

  assign timeout_hit = (timeout_cycles_i != '0) && (cnt_q == timeout_cycles_i);
  assign ch_done_o   = ch_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      stop_on_fail_q <= 1'b0;
      cnt_q          <= '0;
      ch_done_q      <= '0;
      for (int i = 0; i < NumChan; i++) code_q[i] <= '0;
      busy_o         <= 1'b0;
      eoc_o          <= 1'b0;
      exit_code_o    <= '0;
      timeout_o      <= 1'b0;
      fail_chan_o    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm_i) begin
            state_q        <= RUN;
            stop_on_fail_q <= stop_on_fail_i;
            cnt_q          <= '0;
            ch_done_q      <= '0;
            for (int i = 0; i < NumChan; i++) code_q[i] <= '0;
            busy_o         <= 1'b1;
            eoc_o          <= 1'b0;
            exit_code_o    <= '0;
            timeout_o      <= 1'b0;
            fail_chan_o    <= '0;
          end
        end
        RUN: begin
          ch_done_q <= done_nxt;
          code_q    <= code_nxt;
          if (stop_on_fail_q && any_fail) begin
            state_q     <= DRAIN;
            exit_code_o <= fail_code;
            fail_chan_o <= fail_idx;
          end else if (all_done) begin
            // fail_code/fail_idx are already 0 when no channel failed.
            state_q     <= DRAIN;
            exit_code_o <= fail_code;
            fail_chan_o <= fail_idx;
          end else if (timeout_hit) begin
            state_q     <= DRAIN;
            timeout_o   <= 1'b1;
            exit_code_o <= '1;
            fail_chan_o <= undone_idx;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!drain_busy_i) begin
            state_q <= DONE;
            busy_o  <= 1'b0;
            eoc_o   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
